// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache fetch responder.
package icache_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int NUM_LINES  = 32;
  localparam int LINE_WORDS = 8;
  localparam int MEM_LAT    = 4;

  localparam int ADDR_W      = 16;
  localparam int WORD_W      = 16;
  localparam int BYTE_OFF    = 1;
  localparam int OFFSET_W    = 3;
  localparam int INDEX_W     = $clog2(NUM_LINES);
  localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W - BYTE_OFF;
  localparam int LINE_ADDR_W = ADDR_W - OFFSET_W - BYTE_OFF;

  // Rebuild a halfword-aligned byte address from a line number and word offset.
  // The offset is concatenated, never added, so a line near 16'hFFF0 cannot carry.
  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [LINE_ADDR_W-1:0] line,
    input logic [OFFSET_W-1:0]    off
  );
    return {line, off, {BYTE_OFF{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Direct-mapped line storage: valid bits, tags and data words.
// Asynchronous read of one word plus its line's valid/tag; synchronous writes.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = icache_pkg::NUM_LINES,
  parameter int LINE_WORDS = icache_pkg::LINE_WORDS,
  parameter int IDX_W      = $clog2(NUM_LINES),
  parameter int TG_W       = ADDR_W - IDX_W - OFFSET_W - BYTE_OFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic                rd_valid,
  output logic [TG_W-1:0]     rd_tag,
  output logic [WORD_W-1:0]   rd_word,
  input  logic                inval_en,
  input  logic [IDX_W-1:0]    inval_index,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic                tag_wr,
  input  logic [TG_W-1:0]     wr_tag
);

  logic [NUM_LINES-1:0] valid_bits;
  logic [TG_W-1:0]      tag_mem  [NUM_LINES];
  logic [WORD_W-1:0]    data_mem [NUM_LINES][LINE_WORDS];

  assign rd_valid = valid_bits[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_word  = data_mem[rd_index][rd_offset];

  // Valid bits: global clear on reset, per-line clear when a refill starts,
  // set together with the tag when the last word of the line lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
    end else begin
      if (inval_en) valid_bits[inval_index] <= 1'b0;
      if (tag_wr)   valid_bits[wr_index]    <= 1'b1;
    end
  end

  // Tag array is written once per refill, on the final return.
  always_ff @(posedge clk) begin
    if (tag_wr) tag_mem[wr_index] <= wr_tag;
  end

  // Data array takes one returned word per cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) data_mem[wr_index][wr_offset] <= wr_data;
  end

endmodule

// File: rtl/icache_fetch_responder.sv
// Fetch-side instruction cache responder: combinational hit path, stall on miss,
// and a back-to-back line refill from a fixed-latency pipelined memory.
module icache_fetch_responder
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = icache_pkg::NUM_LINES,
  parameter int LINE_WORDS = icache_pkg::LINE_WORDS,
  parameter int MEM_LAT    = icache_pkg::MEM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [WORD_W-1:0] inst,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  localparam int IDX_W    = $clog2(NUM_LINES);
  localparam int TG_W     = ADDR_W - IDX_W - OFFSET_W - BYTE_OFF;
  localparam int CNT_W    = OFFSET_W + 1;
  localparam int FILL_MAX = LINE_WORDS + MEM_LAT;
  localparam int AGE_W    = $clog2(FILL_MAX + 1);

  localparam logic [CNT_W-1:0] WORDS_C   = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(FILL_MAX);

  // Address fields of the current PC.
  logic [OFFSET_W-1:0] fetch_off;
  logic [IDX_W-1:0]    fetch_idx;
  logic [TG_W-1:0]     fetch_tag;
  logic                unused_byte_bit;

  assign fetch_off       = fetch_addr[OFFSET_W+BYTE_OFF-1:BYTE_OFF];
  assign fetch_idx       = fetch_addr[OFFSET_W+BYTE_OFF +: IDX_W];
  assign fetch_tag       = fetch_addr[ADDR_W-1 -: TG_W];
  assign unused_byte_bit = fetch_addr[0];

  // Control state.
  state_t           state;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [AGE_W-1:0] fill_age;

  // Line being refilled; index and tag are slices of it.
  logic [LINE_ADDR_W-1:0] fill_line;
  logic [IDX_W-1:0]       fill_idx;
  logic [TG_W-1:0]        fill_tag;

  assign fill_idx = fill_line[IDX_W-1:0];
  assign fill_tag = fill_line[LINE_ADDR_W-1 -: TG_W];

  // Array read port and derived hit/miss.
  logic              rd_valid;
  logic [TG_W-1:0]   rd_tag;
  logic [WORD_W-1:0] rd_word;
  logic              hit;
  logic              miss;
  logic              issuing;
  logic              ret_fire;
  logic              last_ret;

  assign hit      = rd_valid && (rd_tag == fetch_tag);
  assign miss     = (state == IDLE) && fetch_req && !hit;
  assign issuing  = (state == FILL) && (issue_cnt < WORDS_C);
  assign ret_fire = (state == FILL) && mem_rvalid;
  assign last_ret = ret_fire && (ret_cnt == LAST_WORD);

  // Outputs: the miss-detect cycle already stalls; FILL always stalls.
  assign stall    = (state == FILL) || miss;
  assign inst     = ((state == IDLE) && fetch_req && hit) ? rd_word : '0;
  assign mem_req  = issuing;
  assign mem_addr = issuing ? word_addr(fill_line, issue_cnt[OFFSET_W-1:0]) : '0;

  icache_line_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS),
    .IDX_W     (IDX_W),
    .TG_W      (TG_W)
  ) u_lines (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (fetch_idx),
    .rd_offset  (fetch_off),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_word    (rd_word),
    .inval_en   (miss),
    .inval_index(fetch_idx),
    .wr_en      (ret_fire),
    .wr_index   (fill_idx),
    .wr_offset  (ret_cnt[OFFSET_W-1:0]),
    .wr_data    (mem_rdata),
    .tag_wr     (last_ret),
    .wr_tag     (fill_tag)
  );

  // FSM and counters: enter FILL on a miss, issue and collect LINE_WORDS words,
  // return to IDLE on the last word. Redirects and fetch_req drops do not abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      fill_age  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state     <= FILL;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            fill_age  <= '0;
          end
        end
        FILL: begin
          fill_age <= fill_age + 1'b1;
          if (issuing)  issue_cnt <= issue_cnt + 1'b1;
          if (ret_fire) ret_cnt   <= ret_cnt + 1'b1;
          if (last_ret) state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Latch the missing line's address; held for the whole refill.
  always_ff @(posedge clk) begin
    if (miss) fill_line <= fetch_addr[ADDR_W-1:OFFSET_W+BYTE_OFF];
  end

  // A refill must finish within LINE_WORDS + MEM_LAT cycles of entering FILL.
  always_ff @(posedge clk) begin
    if (!rst && (state == FILL)) assert (fill_age < AGE_LIMIT);
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Self-checking bench for icache_fetch_responder with a fixed-latency memory model.
module tb_icache_fetch_responder;

  localparam int MEM_LAT_TB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [15:0] inst;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues: {cycle[15:0], address[15:0]} for memory requests.
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [15:0] exp_inst_q[$];

  always #5 clk = ~clk;

  icache_fetch_responder #(
    .NUM_LINES (32),
    .LINE_WORDS(8),
    .MEM_LAT   (MEM_LAT_TB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_req),
    .fetch_addr(fetch_addr),
    .inst      (inst),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  // Memory model: word at byte address a holds 16'hA000 + a/2.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 + {1'b0, a[15:1]};
  endfunction

  logic        pipe_vld  [MEM_LAT_TB];
  logic [15:0] pipe_addr [MEM_LAT_TB];
  logic        stray_vld;
  logic [15:0] stray_data;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT_TB; i++) pipe_vld[i] <= 1'b0;
    end else begin
      pipe_vld[0]  <= mem_req;
      pipe_addr[0] <= mem_addr;
      for (int i = 1; i < MEM_LAT_TB; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  assign mem_rvalid = pipe_vld[MEM_LAT_TB-1] | stray_vld;
  assign mem_rdata  = stray_vld ? stray_data : mem_word(pipe_addr[MEM_LAT_TB-1]);

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected requests for one line: eight words, first one in cycle c0.
  task automatic push_line(input logic [15:0] base, input int c0);
    for (int i = 0; i < 8; i++) exp_q.push_back({16'(c0 + i), base + 16'(2 * i)});
  endtask

  // Present a fetch until it is served; records requests and counts stall cycles.
  // Cycle 0 is the first cycle the request is presented. stalls = -1 on timeout.
  task automatic run_fetch(input logic [15:0] addr, input logic [15:0] redir_addr,
                           input int redir_cyc, output int stalls, output logic [15:0] inst_out);
    bit done = 0;
    obs_q.delete();
    stalls    = 0;
    inst_out  = 16'h0000;
    fetch_req = 1'b1;
    fetch_addr = addr;
    for (int k = 0; k < 60; k++) begin
      if (k == redir_cyc) fetch_addr = redir_addr;
      @(negedge clk);
      if (mem_req) obs_q.push_back({16'(k), mem_addr});
      if (!stall) begin
        inst_out = inst;
        done = 1;
      end else begin
        stalls++;
      end
      next_cycle();
      if (done) break;
    end
    if (!done) stalls = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = 16'h0000;
    stray_vld = 1'b0; stray_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin $display("FAIL reset_stall: got %0b expected 0", stall); failures++; end
    checks++; if (mem_req !== 1'b0) begin $display("FAIL reset_mem_req: got %0b expected 0", mem_req); failures++; end
    checks++; if (mem_addr !== 16'h0000) begin $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); failures++; end
    checks++; if (inst !== 16'h0000) begin $display("FAIL reset_inst: got %h expected 0000", inst); failures++; end
    next_cycle();
  endtask

  task automatic test_first_fill();
    int st; logic [15:0] iv; logic [31:0] e, o;
    push_line(16'h0000, 1);
    run_fetch(16'h0000, 16'h0000, -1, st, iv);
    fetch_req = 1'b0;
    checks++; if (st != 13) begin $display("FAIL fill0_stalls: got %0d expected 13", st); failures++; end
    checks++; if (iv !== 16'hA000) begin $display("FAIL fill0_inst: got %h expected a000", iv); failures++; end
    checks++; if (obs_q.size() != exp_q.size()) begin $display("FAIL fill0_req_count: got %0d expected %0d", obs_q.size(), exp_q.size()); failures++; end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin $display("FAIL fill0_req: got cyc %0d addr %h expected cyc %0d addr %h", o[31:16], o[15:0], e[31:16], e[15:0]); failures++; end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_seq_hits();
    logic [15:0] e16;
    for (int a = 2; a <= 14; a += 2) begin
      fetch_req = 1'b1; fetch_addr = 16'(a);
      exp_inst_q.push_back(mem_word(16'(a)));
      @(negedge clk);
      e16 = exp_inst_q.pop_front();
      checks++; if (inst !== e16) begin $display("FAIL seq_inst: got %h expected %h", inst, e16); failures++; end
      checks++; if (stall !== 1'b0) begin $display("FAIL seq_stall: got %0b expected 0", stall); failures++; end
      checks++; if (mem_req !== 1'b0) begin $display("FAIL seq_mem_req: got %0b expected 0", mem_req); failures++; end
      next_cycle();
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_conflict();
    int st; logic [15:0] iv; logic [31:0] e, o;
    push_line(16'h0200, 1);
    run_fetch(16'h0200, 16'h0000, -1, st, iv);
    checks++; if (st != 13) begin $display("FAIL conflict_stalls: got %0d expected 13", st); failures++; end
    checks++; if (iv !== 16'hA100) begin $display("FAIL conflict_inst: got %h expected a100", iv); failures++; end
    checks++; if (obs_q.size() != exp_q.size()) begin $display("FAIL conflict_req_count: got %0d expected %0d", obs_q.size(), exp_q.size()); failures++; end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin $display("FAIL conflict_req: got cyc %0d addr %h expected cyc %0d addr %h", o[31:16], o[15:0], e[31:16], e[15:0]); failures++; end
    end
    exp_q.delete(); obs_q.delete();
    push_line(16'h0000, 1);
    run_fetch(16'h0000, 16'h0000, -1, st, iv);
    fetch_req = 1'b0;
    checks++; if (st != 13) begin $display("FAIL refetch_stalls: got %0d expected 13", st); failures++; end
    checks++; if (iv !== 16'hA000) begin $display("FAIL refetch_inst: got %h expected a000", iv); failures++; end
    checks++; if (obs_q.size() != exp_q.size()) begin $display("FAIL refetch_req_count: got %0d expected %0d", obs_q.size(), exp_q.size()); failures++; end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin $display("FAIL refetch_req: got cyc %0d addr %h expected cyc %0d addr %h", o[31:16], o[15:0], e[31:16], e[15:0]); failures++; end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_idle();
    fetch_req = 1'b0; fetch_addr = 16'h0800;
    stray_vld = 1'b1; stray_data = 16'hDEAD;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (inst !== 16'h0000) begin $display("FAIL idle_inst: got %h expected 0000", inst); failures++; end
      checks++; if (stall !== 1'b0) begin $display("FAIL idle_stall: got %0b expected 0", stall); failures++; end
      checks++; if (mem_req !== 1'b0) begin $display("FAIL idle_mem_req: got %0b expected 0", mem_req); failures++; end
      next_cycle();
      stray_vld = 1'b0;
    end
    fetch_req = 1'b1; fetch_addr = 16'h0000;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin $display("FAIL stray_stall: got %0b expected 0", stall); failures++; end
    checks++; if (inst !== 16'hA000) begin $display("FAIL stray_inst: got %h expected a000", inst); failures++; end
    next_cycle();
    fetch_req = 1'b0;
  endtask

  task automatic test_redirect();
    int st; logic [15:0] iv; logic [31:0] e, o;
    push_line(16'h0010, 1);
    push_line(16'h0420, 14);
    run_fetch(16'h0010, 16'h0420, 3, st, iv);
    checks++; if (st != 26) begin $display("FAIL redir_stalls: got %0d expected 26", st); failures++; end
    checks++; if (iv !== 16'hA210) begin $display("FAIL redir_inst: got %h expected a210", iv); failures++; end
    checks++; if (obs_q.size() != exp_q.size()) begin $display("FAIL redir_req_count: got %0d expected %0d", obs_q.size(), exp_q.size()); failures++; end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin $display("FAIL redir_req: got cyc %0d addr %h expected cyc %0d addr %h", o[31:16], o[15:0], e[31:16], e[15:0]); failures++; end
    end
    exp_q.delete(); obs_q.delete();
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin $display("FAIL redir_old_stall: got %0b expected 0", stall); failures++; end
    checks++; if (inst !== 16'hA008) begin $display("FAIL redir_old_inst: got %h expected a008", inst); failures++; end
    next_cycle();
    fetch_req = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    int st; logic [15:0] iv; logic [31:0] e, o;
    fetch_req = 1'b1; fetch_addr = 16'h0030;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (stall !== 1'b1) begin $display("FAIL rmf_detect_stall: got %0b expected 1", stall); failures++; end
      end
      next_cycle();
    end
    rst = 1'b1; fetch_req = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin $display("FAIL rmf_mem_req: got %0b expected 0", mem_req); failures++; end
    checks++; if (stall !== 1'b0) begin $display("FAIL rmf_stall: got %0b expected 0", stall); failures++; end
    checks++; if (mem_addr !== 16'h0000) begin $display("FAIL rmf_mem_addr: got %h expected 0000", mem_addr); failures++; end
    next_cycle();
    push_line(16'h0030, 1);
    run_fetch(16'h0030, 16'h0000, -1, st, iv);
    fetch_req = 1'b0;
    checks++; if (st != 13) begin $display("FAIL rmf_refill_stalls: got %0d expected 13", st); failures++; end
    checks++; if (iv !== 16'hA018) begin $display("FAIL rmf_refill_inst: got %h expected a018", iv); failures++; end
    checks++; if (obs_q.size() != exp_q.size()) begin $display("FAIL rmf_req_count: got %0d expected %0d", obs_q.size(), exp_q.size()); failures++; end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin $display("FAIL rmf_req: got cyc %0d addr %h expected cyc %0d addr %h", o[31:16], o[15:0], e[31:16], e[15:0]); failures++; end
    end
    exp_q.delete(); obs_q.delete();
    next_cycle();
    run_fetch(16'h0000, 16'h0000, -1, st, iv);
    fetch_req = 1'b0;
    checks++; if (st != 13) begin $display("FAIL rmf_cleared_stalls: got %0d expected 13", st); failures++; end
    checks++; if (iv !== 16'hA000) begin $display("FAIL rmf_cleared_inst: got %h expected a000", iv); failures++; end
    obs_q.delete();
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = 16'h0000;
    stray_vld = 1'b0; stray_data = 16'h0000;
    test_reset();
    test_first_fill();
    test_seq_hits();
    test_conflict();
    test_idle();
    test_redirect();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
